// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 video timing constants (25 MHz pixel clock).
// Pure constants package: no ports, no logic.
// Consumed by vga_timing_gen and hdmi_video_output as parameter defaults.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;  // 525

endpackage

// File: rtl/vga_timing_gen.sv
// Purpose : h/v raster counters plus raw (undelayed) de and active-low hs/vs.
// Latency : de/hs/vs are combinational from the registered counters; v_next is the
//           value v takes at the next edge. Ports: video_clk, rst_n in; h, v, v_next, de, hs, vs out.
// Backpressure: none, free-running raster.
module vga_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SP  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SP  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic       video_clk,
  input  logic       rst_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic [9:0] v_next,
  output logic       de,
  output logic       hs,
  output logic       vs
);

  localparam int H_TOT = H_ACT + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SP + V_BP;

  logic [9:0] h_next;

  always_comb begin
    h_next = h + 10'd1;
    v_next = v;
    if (h == 10'(H_TOT - 1)) begin
      h_next = '0;
      v_next = (v == 10'(V_TOT - 1)) ? '0 : v + 10'd1;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_next;
      v <= v_next;
    end
  end

  assign de = (h < 10'(H_ACT)) && (v < 10'(V_ACT));
  assign hs = !((h >= 10'(H_ACT + H_FP)) && (h < 10'(H_ACT + H_FP + H_SP)));
  assign vs = !((v >= 10'(V_ACT + V_FP)) && (v < 10'(V_ACT + V_FP + V_SP)));

endmodule

// File: rtl/hdmi_video_output.sv
// Purpose : VGA/HDMI scan-out of a 320x240 PPU image doubled 2x2, row RAM -> palette RAM -> RGB.
// Latency : vga_rgb/de/hs/vs are 3 video_clk cycles behind the raster counters; PPU control
//           pulses and next_row are aligned to the counters. Backpressure: none (fixed-rate raster).
// Ports   : video_clk/rst_n; vga_* outputs; rowram/palram read ports; rowram_swap, vblank_start,
//           vblank_end_soon, next_row to the PPU.
module hdmi_video_output
  import video_timing_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SP  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SP  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic        video_clk,
  input  logic        rst_n,
  output logic        vga_pclk,
  output logic        vga_de,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [23:0] vga_rgb,
  output logic [8:0]  rowram_rdaddr,
  input  logic [9:0]  rowram_rddata,
  output logic [8:0]  palram_rdaddr,
  input  logic [63:0] palram_rddata,
  output logic        rowram_swap,
  output logic        vblank_start,
  output logic        vblank_end_soon,
  output logic [7:0]  next_row
);

  localparam int H_TOT = H_ACT + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SP + V_BP;

  logic [9:0]  h, v, v_next;
  logic        de_raw, hs_raw, vs_raw;
  logic        de_d1, hs_d1, vs_d1;
  logic        de_d2, hs_d2, vs_d2;
  logic        sel_d2;
  logic [23:0] pix;
  logic        unused_bits;

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SP(H_SP), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SP(V_SP), .V_BP(V_BP)
  ) u_timing (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .h         (h),
    .v         (v),
    .v_next    (v_next),
    .de        (de_raw),
    .hs        (hs_raw),
    .vs        (vs_raw)
  );

  assign vga_pclk = video_clk;

  // Cycle t: column address out; t+1: palette reference returns and feeds the
  // palette address; t+2: colour word returns alongside the registered half-select.
  assign rowram_rdaddr = (h < 10'(H_ACT)) ? h[9:1] : '0;
  assign palram_rdaddr = rowram_rddata[9:1];
  assign pix           = sel_d2 ? palram_rddata[55:32] : palram_rddata[23:0];

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d1    <= 1'b0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      de_d2    <= 1'b0;
      hs_d2    <= 1'b1;
      vs_d2    <= 1'b1;
      sel_d2   <= 1'b0;
      vga_de   <= 1'b0;
      vga_hs   <= 1'b1;
      vga_vs   <= 1'b1;
      vga_rgb  <= '0;
      next_row <= '0;
    end else begin
      de_d1    <= de_raw;
      hs_d1    <= hs_raw;
      vs_d1    <= vs_raw;
      de_d2    <= de_d1;
      hs_d2    <= hs_d1;
      vs_d2    <= vs_d1;
      sel_d2   <= rowram_rddata[0];
      vga_de   <= de_d2;
      vga_hs   <= hs_d2;
      vga_vs   <= vs_d2;
      vga_rgb  <= de_d2 ? pix : '0;
      // Computed from the upcoming v so the registered value lines up with the counter.
      next_row <= (v_next < 10'(V_ACT - 2)) ? v_next[8:1] + 8'd1 : '0;
    end
  end

  // Swap after the second (odd) display line of each PPU row has been scanned.
  assign rowram_swap     = (h == 10'(H_TOT - 1)) && (v < 10'(V_ACT)) && v[0];
  assign vblank_start    = (h == 10'd0) && (v == 10'(V_ACT));
  assign vblank_end_soon = (h == 10'd0) && (v == 10'(V_TOT - 2));

  assign unused_bits = ^{palram_rddata[63:56], palram_rddata[31:24], v_next[9]};

endmodule

// File: tb/tb_hdmi_video_output.sv
`timescale 1ns/100ps
module tb_hdmi_video_output;

  // Reduced raster so several whole frames fit in a short run; same structure as 640x480.
  localparam int HA = 40, HF = 4, HS = 8, HB = 8, HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VS = 2, VB = 6, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_pclk, vga_de, vga_hs, vga_vs;
  logic [23:0] vga_rgb;
  logic [8:0]  rowram_rdaddr, palram_rdaddr;
  logic [9:0]  rowram_rddata;
  logic [63:0] palram_rddata;
  logic        rowram_swap, vblank_start, vblank_end_soon;
  logic [7:0]  next_row;

  hdmi_video_output #(
    .H_ACT(HA), .H_FP(HF), .H_SP(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SP(VS), .V_BP(VB)
  ) dut (
    .video_clk       (video_clk),
    .rst_n           (rst_n),
    .vga_pclk        (vga_pclk),
    .vga_de          (vga_de),
    .vga_hs          (vga_hs),
    .vga_vs          (vga_vs),
    .vga_rgb         (vga_rgb),
    .rowram_rdaddr   (rowram_rdaddr),
    .rowram_rddata   (rowram_rddata),
    .palram_rdaddr   (palram_rdaddr),
    .palram_rddata   (palram_rddata),
    .rowram_swap     (rowram_swap),
    .vblank_start    (vblank_start),
    .vblank_end_soon (vblank_end_soon),
    .next_row        (next_row)
  );

  always #20 video_clk = ~video_clk;

  // Synchronous-read RAM models, 1-cycle latency.
  logic [9:0]  rowmem [0:511];
  logic [63:0] palmem [0:511];
  always @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      rowram_rddata <= '0;
      palram_rddata <= '0;
    end else begin
      rowram_rddata <= rowmem[rowram_rdaddr];
      palram_rddata <= palmem[palram_rdaddr];
    end
  end

  // Cycles since reset release: the raster position is derived from this alone.
  int t;
  always @(posedge video_clk or negedge rst_n)
    if (!rst_n) t <= 0; else t <= t + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  function automatic int mh(input int tt); return tt % HT; endfunction
  function automatic int mv(input int tt); return (tt / HT) % VT; endfunction
  function automatic int exp_rdaddr(input int tt);
    return (mh(tt) < HA) ? mh(tt) / 2 : 0;
  endfunction
  function automatic logic [23:0] colour(input int col);
    logic [9:0]  idx;
    logic [63:0] w;
    idx = rowmem[col];
    w   = palmem[idx >> 1];
    return idx[0] ? w[55:32] : w[23:0];
  endfunction

  // Per-cycle scoreboard plus per-frame aggregates.
  bit mon_en = 0;
  int hs_lo, vs_lo, de_n, sw_n, sw_first, sw_last, vst_n, ven_n, last_fall;
  bit prev_vs;

  task automatic mon_restart();
    hs_lo = 0; vs_lo = 0; de_n = 0; sw_n = 0; sw_first = -1; sw_last = -1;
    vst_n = 0; ven_n = 0; last_fall = -1; prev_vs = 1'b1;
  endtask

  always @(negedge video_clk) begin
    int h0, v0, s, hs0, vs0;
    bit de0, ehs, evs;
    logic [23:0] ergb;
    if (mon_en) begin
      h0 = mh(t);
      v0 = mv(t);
      chk("rowram_rdaddr", rowram_rdaddr, exp_rdaddr(t));
      chk("palram_rdaddr", palram_rdaddr, (t == 0) ? 0 : int'(rowmem[exp_rdaddr(t - 1)] >> 1));
      chk("rowram_swap", rowram_swap, (h0 == HT - 1) && (v0 < VA) && (v0 % 2 == 1));
      chk("vblank_start", vblank_start, (h0 == 0) && (v0 == VA));
      chk("vblank_end_soon", vblank_end_soon, (h0 == 0) && (v0 == VT - 2));
      chk("next_row", next_row, (t > 0 && v0 < VA - 2) ? v0 / 2 + 1 : 0);
      chk("vga_pclk", vga_pclk, video_clk);
      s = t - 3;
      if (s < 0) begin
        de0 = 0; ehs = 1; evs = 1; ergb = '0;
      end else begin
        hs0  = mh(s);
        vs0  = mv(s);
        de0  = (hs0 < HA) && (vs0 < VA);
        ehs  = !(hs0 >= HA + HF && hs0 < HA + HF + HS);
        evs  = !(vs0 >= VA + VF && vs0 < VA + VF + VS);
        ergb = de0 ? colour(hs0 / 2) : 24'h0;
      end
      chk("vga_de", vga_de, de0);
      chk("vga_hs", vga_hs, ehs);
      chk("vga_vs", vga_vs, evs);
      chk("vga_rgb", vga_rgb, ergb);
      if (s >= 0) begin
        if (!vga_hs) hs_lo++;
        if (!vga_vs) vs_lo++;
        if (vga_de)  de_n++;
        if (s % FT == FT - 1) begin
          chk("hs_low_per_frame", hs_lo, HS * VT);
          chk("vs_low_per_frame", vs_lo, VS * HT);
          chk("de_high_per_frame", de_n, HA * VA);
          hs_lo = 0; vs_lo = 0; de_n = 0;
        end
      end
      if (prev_vs && !vga_vs) begin
        if (last_fall >= 0) chk("frame_length", t - last_fall, FT);
        last_fall = t;
      end
      prev_vs = vga_vs;
      if (rowram_swap) begin
        if (sw_n == 0) sw_first = t % FT;
        sw_last = t % FT;
        sw_n++;
      end
      if (vblank_start)    vst_n++;
      if (vblank_end_soon) ven_n++;
      if (t % FT == FT - 1) begin
        chk("swap_count", sw_n, VA / 2);
        chk("swap_first_pos", sw_first, 1 * HT + HT - 1);
        chk("swap_last_pos", sw_last, (VA - 1) * HT + HT - 1);
        chk("vblank_start_count", vst_n, 1);
        chk("vblank_end_soon_count", ven_n, 1);
        sw_n = 0; sw_first = -1; sw_last = -1; vst_n = 0; ven_n = 0;
      end
    end
  end

  // Advance (on negedges) until the raster is at (h,v); bounded by just over a frame.
  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(mh(t) == h && mv(t) == v) && n < FT + 10) begin
      @(negedge video_clk);
      n++;
    end
    if (n >= FT + 10) begin
      checks++;
      failures++;
      $display("FAIL wait_pos h=%0d v=%0d not reached within %0d cycles", h, v, n);
    end
  endtask

  typedef struct {
    int h; int v; int rdaddr; bit swap; bit vst; bit ven; int nrow;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL timeout global time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0,      0,      0,  1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{6,      0,      3,  1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{HT-1,   0,      0,  1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{HT-1,   1,      0,  1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{HA-1,   2,      19, 1'b0, 1'b0, 1'b0, 2};
    tbl[5]  = '{0,      16,     0,  1'b0, 1'b0, 1'b0, 9};
    tbl[6]  = '{0,      17,     0,  1'b0, 1'b0, 1'b0, 9};
    tbl[7]  = '{0,      18,     0,  1'b0, 1'b0, 1'b0, 0};
    tbl[8]  = '{HT-1,   VA-1,   0,  1'b1, 1'b0, 1'b0, 0};
    tbl[9]  = '{0,      VA,     0,  1'b0, 1'b1, 1'b0, 0};
    tbl[10] = '{1,      VA,     0,  1'b0, 1'b0, 1'b0, 0};
    tbl[11] = '{0,      VT-2,   0,  1'b0, 1'b0, 1'b1, 0};
    tbl[12] = '{1,      VT-2,   0,  1'b0, 1'b0, 1'b0, 0};

    for (int i = 0; i < 512; i++) begin
      rowmem[i] = 10'($urandom);
      palmem[i] = {$urandom, $urandom};
    end

    // Reset state.
    repeat (3) @(negedge video_clk);
    chk("rst_vga_de", vga_de, 1'b0);
    chk("rst_vga_hs", vga_hs, 1'b1);
    chk("rst_vga_vs", vga_vs, 1'b1);
    chk("rst_vga_rgb", vga_rgb, 24'h0);
    chk("rst_rowram_swap", rowram_swap, 1'b0);
    chk("rst_vblank_start", vblank_start, 1'b0);
    chk("rst_vblank_end_soon", vblank_end_soon, 1'b0);
    chk("rst_next_row", next_row, 8'd0);
    chk("rst_rowram_rdaddr", rowram_rdaddr, 9'd0);

    // Random RAM contents, three frames under the scoreboard, table in frame 1.
    mon_restart();
    rst_n = 1'b1;
    mon_en = 1;
    wait_pos(HT - 1, VT - 1);
    @(negedge video_clk);
    for (int i = 0; i < 13; i++) begin
      wait_pos(tbl[i].h, tbl[i].v);
      chk("tbl_rowram_rdaddr", rowram_rdaddr, tbl[i].rdaddr);
      chk("tbl_rowram_swap", rowram_swap, tbl[i].swap);
      chk("tbl_vblank_start", vblank_start, tbl[i].vst);
      chk("tbl_vblank_end_soon", vblank_end_soon, tbl[i].ven);
      chk("tbl_next_row", next_row, tbl[i].nrow);
    end
    wait_pos(HT - 1, VT - 1);
    repeat (5) @(negedge video_clk);

    // Mid-line asynchronous reset for 1 ns, then restart with column-echo contents.
    wait_pos(20, VA / 2);
    #5;
    mon_en = 0;
    rst_n = 1'b0;
    #0.5;
    chk("arst_vga_de", vga_de, 1'b0);
    chk("arst_vga_hs", vga_hs, 1'b1);
    chk("arst_vga_vs", vga_vs, 1'b1);
    chk("arst_vga_rgb", vga_rgb, 24'h0);
    chk("arst_rowram_swap", rowram_swap, 1'b0);
    chk("arst_next_row", next_row, 8'd0);
    chk("arst_rowram_rdaddr", rowram_rdaddr, 9'd0);
    for (int i = 0; i < 512; i++) begin
      rowmem[i] = 10'(i);
      palmem[i] = {32'h00AABBCC, 32'h00112233};
    end
    #0.5;
    rst_n = 1'b1;
    mon_restart();
    mon_en = 1;

    wait_pos(6, 0);
    chk("echo_rowram_rdaddr_h6", rowram_rdaddr, 9'd3);
    @(negedge video_clk);
    chk("echo_palram_rdaddr", palram_rdaddr, 9'd1);
    repeat (2) @(negedge video_clk);
    chk("echo_rgb_odd", vga_rgb, 24'hAABBCC);
    chk("echo_de", vga_de, 1'b1);
    repeat (2) @(negedge video_clk);
    chk("echo_rgb_even", vga_rgb, 24'h112233);
    @(posedge video_clk);
    #1;
    chk("pclk_high", vga_pclk, video_clk);

    wait_pos(HT - 1, VT - 1);
    repeat (5) @(negedge video_clk);
    mon_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
